alu_input_seq: RTL and testbench

ALU_INPUT_SEQ -- requirements
Module: alu_input_seq

---
 rtl/alu_input_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_input_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_input_seq.sv
// Purpose: debounces four pushbuttons and steps a LOAD_A/LOAD_B/LOAD_OP/SHOW sequencer that latches ALU operands and opcode from the switches.
// Latency: a held raw press updates the registers DEBOUNCE_CYCLES+3 edges after the first edge that samples it.
// Backpressure: none; events are one-cycle pulses, and any event the current state does not use is dropped.
module alu_input_seq #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  key_n,
  input  logic [16:0] sw,
  output logic [31:0] port_A,
  output logic [31:0] port_B,
  output logic [3:0]  aluop,
  output logic        op_valid,
  output logic [1:0]  state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [CW-1:0] r_cnt [4];
  logic [2:0]    r_deb_d1;
  logic [1:0]    r_settle;
  logic [2:0]    r_arm;
  logic [2:0]    r_press;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_port_a;
  logic [31:0]   r_port_b;
  logic [3:0]    r_aluop;
  logic          r_op_valid;

  logic          w_enter;
  logic          w_cancel;
  logic          w_swap;
  logic          w_ld_a;
  logic          w_ld_b;
  logic          w_ld_op;
  logic          w_do_swap;
  logic [31:0]   w_capture;

  // Two-flop synchronizer for the raw active-low keys; resets to released.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_deb <= '1;
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (r_sync2[k] != r_deb[k]) begin
          if (r_cnt[k] == CNT_LAST) begin
            r_deb[k] <= r_sync2[k];
            r_cnt[k] <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + 1'b1;
          end
        end else begin
          r_cnt[k] <= '0;
        end
      end
    end
  end

  // Arm a key only once its synchronized level has been seen released after the
  // synchronizer has flushed, so a key held through reset cannot fire on its own.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_settle <= '0;
      r_arm    <= '0;
    end else begin
      r_settle <= {r_settle[0], 1'b1};
      r_arm    <= r_arm | ({3{r_settle[1]}} & r_sync2[2:0]);
    end
  end

  // One-cycle press pulse in the cycle after the debounced level falls; KEY3 has no role.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_deb_d1 <= '1;
      r_press  <= '0;
    end else begin
      r_deb_d1 <= r_deb[2:0];
      r_press  <= r_deb_d1 & ~r_deb[2:0] & r_arm;
    end
  end

  assign w_enter  = r_press[0];
  assign w_cancel = r_press[1];
  assign w_swap   = r_press[2];

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= LOAD_A;
    else       r_state <= w_state_nxt;
  end

  // Next state: cancel beats enter, enter beats swap; swap never changes state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cancel) begin
      w_state_nxt = LOAD_A;
    end else if (w_enter) begin
      case (r_state)
        LOAD_A:  w_state_nxt = LOAD_B;
        LOAD_B:  w_state_nxt = LOAD_OP;
        LOAD_OP: w_state_nxt = SHOW;
        default: w_state_nxt = LOAD_A;
      endcase
    end
  end

  // FSM outputs: register load/swap strobes, suppressed by any higher-priority event.
  always_comb begin
    w_ld_a    = 1'b0;
    w_ld_b    = 1'b0;
    w_ld_op   = 1'b0;
    w_do_swap = 1'b0;
    if (!w_cancel) begin
      if (w_enter) begin
        w_ld_a  = (r_state == LOAD_A);
        w_ld_b  = (r_state == LOAD_B);
        w_ld_op = (r_state == LOAD_OP);
      end else if (w_swap) begin
        w_do_swap = (r_state == SHOW);
      end
    end
  end

  assign w_capture = {{16{sw[16]}}, sw[15:0]};

  // Operand/opcode registers; switches only matter on a load strobe.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_port_a   <= '0;
      r_port_b   <= '0;
      r_aluop    <= '0;
      r_op_valid <= 1'b0;
    end else begin
      if (w_ld_a) r_port_a <= w_capture;
      if (w_ld_b) r_port_b <= w_capture;
      if (w_ld_op) r_aluop <= sw[3:0];
      if (w_do_swap) begin
        r_port_a <= r_port_b;
        r_port_b <= r_port_a;
      end
      r_op_valid <= (w_state_nxt == SHOW);
    end
  end

  assign port_A   = r_port_a;
  assign port_B   = r_port_b;
  assign aluop    = r_aluop;
  assign op_valid = r_op_valid;
  assign state    = r_state;

endmodule

// File: tb/tb_alu_input_seq.sv
// Bench for alu_input_seq with a short debounce window and a semantic operand/state model.
module tb_alu_input_seq;
  localparam int D = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  key_n;
  logic [16:0] sw;
  logic [31:0] port_A;
  logic [31:0] port_B;
  logic [3:0]  aluop;
  logic        op_valid;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [3:0]  m_op;
  logic [1:0]  m_st;
  logic [70:0] pre;
  logic [70:0] held;
  logic [31:0] saved_b;

  alu_input_seq #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .nRST(nRST), .key_n(key_n), .sw(sw),
    .port_A(port_A), .port_B(port_B), .aluop(aluop),
    .op_valid(op_valid), .state(state)
  );

  always #5 CLK = ~CLK;

  wire [70:0] dut_out = {port_A, port_B, aluop, op_valid, state};

  function automatic logic [70:0] exp_out();
    return {m_a, m_b, m_op, (m_st == 2'd3), m_st};
  endfunction

  function automatic void model_reset();
    m_a = '0; m_b = '0; m_op = '0; m_st = 2'd0;
  endfunction

  // Behaviour of one committed event: sw is a signed 17-bit number.
  function automatic void model_event(input bit en, input bit cn, input bit sws);
    logic [31:0] cap;
    logic [31:0] t;
    cap = 32'(sw[15:0]) - (sw[16] ? 32'h0001_0000 : 32'h0);
    if (cn) begin
      m_st = 2'd0;
    end else if (en) begin
      case (m_st)
        2'd0: begin m_a = cap; m_st = 2'd1; end
        2'd1: begin m_b = cap; m_st = 2'd2; end
        2'd2: begin m_op = sw[3:0]; m_st = 2'd3; end
        default: m_st = 2'd0;
      endcase
    end else if (sws && m_st == 2'd3) begin
      t = m_a; m_a = m_b; m_b = t;
    end
  endfunction

  // Press keys in mask from the next edge; returns 1ns after edge E0+D+2.
  task automatic press(input logic [3:0] mask);
    @(negedge CLK);
    key_n = key_n & ~mask;
    repeat (D + 3) @(posedge CLK);
    #1;
  endtask

  task automatic release_all();
    @(negedge CLK);
    key_n = 4'hF;
    repeat (D + 6) @(posedge CLK);
  endtask

  // Common press + timing check, done inline per scenario below.
  task automatic test_reset();
    nRST = 1'b0; key_n = 4'hF; sw = 17'(($urandom));
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if (dut_out !== 71'h0) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", dut_out, 71'h0);
    end
    @(negedge CLK); nRST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    n_vec++;
    if (dut_out !== exp_out()) begin
      n_err++; $display("FAIL reset_release: got %h expected %h", dut_out, exp_out());
    end
  endtask

  task automatic test_sequence();
    logic [16:0] vals [3];
    vals[0] = 17'h00005; vals[1] = 17'h1FFFE; vals[2] = 17'h00002;
    for (int i = 0; i < 3; i++) begin
      sw = vals[i];
      pre = exp_out();
      press(4'b0001);
      n_vec++;
      if (dut_out !== pre) begin
        n_err++; $display("FAIL seq_early_%0d: got %h expected %h", i, dut_out, pre);
      end
      model_event(1'b1, 1'b0, 1'b0);
      @(posedge CLK); #1;
      n_vec++;
      if (dut_out !== exp_out()) begin
        n_err++; $display("FAIL seq_update_%0d: got %h expected %h", i, dut_out, exp_out());
      end
      release_all();
    end
    n_vec++;
    if (dut_out !== {32'h0000_0005, 32'hFFFF_FFFE, 4'h2, 1'b1, 2'b11}) begin
      n_err++; $display("FAIL seq_final: got %h expected %h", dut_out,
                        {32'h0000_0005, 32'hFFFF_FFFE, 4'h2, 1'b1, 2'b11});
    end
  endtask

  task automatic test_swap();
    pre = exp_out();
    press(4'b0100);
    n_vec++;
    if (dut_out !== pre) begin
      n_err++; $display("FAIL swap_early: got %h expected %h", dut_out, pre);
    end
    model_event(1'b0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    n_vec++;
    if (dut_out !== {32'hFFFF_FFFE, 32'h0000_0005, 4'h2, 1'b1, 2'b11}) begin
      n_err++; $display("FAIL swap_show: got %h expected %h", dut_out,
                        {32'hFFFF_FFFE, 32'h0000_0005, 4'h2, 1'b1, 2'b11});
    end
    release_all();
    // Move to LOAD_B: SHOW -> LOAD_A -> LOAD_B.
    for (int i = 0; i < 2; i++) begin
      sw = 17'($urandom);
      press(4'b0001);
      model_event(1'b1, 1'b0, 1'b0);
      @(posedge CLK); #1;
      n_vec++;
      if (dut_out !== exp_out()) begin
        n_err++; $display("FAIL swap_setup_%0d: got %h expected %h", i, dut_out, exp_out());
      end
      release_all();
    end
    pre = exp_out();
    press(4'b0100);
    repeat (3) @(posedge CLK); #1;
    n_vec++;
    if (dut_out !== pre || state !== 2'b01) begin
      n_err++; $display("FAIL swap_ignored: got %h expected %h", dut_out, pre);
    end
    release_all();
  endtask

  task automatic test_priority();
    saved_b = m_b;
    sw = 17'($urandom);
    press(4'b0011);
    model_event(1'b1, 1'b1, 1'b0);
    @(posedge CLK); #1;
    n_vec++;
    if (dut_out !== exp_out() || state !== 2'b00 || port_B !== saved_b) begin
      n_err++; $display("FAIL priority: got %h expected %h", dut_out, exp_out());
    end
    release_all();
  endtask

  task automatic test_bounce();
    sw = 17'($urandom);
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      key_n[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(negedge CLK);
        n_vec++;
        if (dut_out !== exp_out()) begin
          n_err++; $display("FAIL bounce_quiet_%0d: got %h expected %h", i, dut_out, exp_out());
        end
      end
    end
    key_n[0] = 1'b0;
    repeat (D + 3) @(posedge CLK);
    #1;
    n_vec++;
    if (dut_out !== exp_out()) begin
      n_err++; $display("FAIL bounce_early: got %h expected %h", dut_out, exp_out());
    end
    model_event(1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    n_vec++;
    if (dut_out !== exp_out()) begin
      n_err++; $display("FAIL bounce_event: got %h expected %h", dut_out, exp_out());
    end
    repeat (20) @(posedge CLK); #1;
    n_vec++;
    if (dut_out !== exp_out()) begin
      n_err++; $display("FAIL bounce_single: got %h expected %h", dut_out, exp_out());
    end
    release_all();
  endtask

  task automatic test_random();
    int k;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 3);
      sw = 17'($urandom);
      pre = exp_out();
      press(4'(1 << k));
      n_vec++;
      if (dut_out !== pre) begin
        n_err++; $display("FAIL rand_early_%0d: got %h expected %h", it, dut_out, pre);
      end
      model_event(k == 0, k == 1, k == 2);
      @(posedge CLK); #1;
      n_vec++;
      if (dut_out !== exp_out()) begin
        n_err++; $display("FAIL rand_update_%0d key%0d: got %h expected %h", it, k, dut_out, exp_out());
      end
      sw = 17'($urandom);
      repeat (3) @(posedge CLK); #1;
      n_vec++;
      if (dut_out !== exp_out()) begin
        n_err++; $display("FAIL rand_sw_hold_%0d: got %h expected %h", it, dut_out, exp_out());
      end
      release_all();
    end
  endtask

  task automatic test_reset_mid();
    // Reach LOAD_OP: cancel, then two enters.
    press(4'b0010);
    model_event(1'b0, 1'b1, 1'b0);
    @(posedge CLK);
    release_all();
    for (int i = 0; i < 2; i++) begin
      sw = 17'($urandom);
      press(4'b0001);
      model_event(1'b1, 1'b0, 1'b0);
      @(posedge CLK);
      release_all();
    end
    #1;
    n_vec++;
    if (dut_out !== exp_out() || state !== 2'b10) begin
      n_err++; $display("FAIL rmid_setup: got %h expected %h", dut_out, exp_out());
    end
    @(negedge CLK);
    key_n[0] = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (dut_out !== 71'h0) begin
      n_err++; $display("FAIL rmid_async: got %h expected %h", dut_out, 71'h0);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    repeat (D + 30) @(posedge CLK); #1;
    n_vec++;
    if (dut_out !== exp_out()) begin
      n_err++; $display("FAIL rmid_held_no_event: got %h expected %h", dut_out, exp_out());
    end
    release_all();
    sw = 17'($urandom);
    press(4'b0001);
    model_event(1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    n_vec++;
    if (dut_out !== exp_out() || state !== 2'b01) begin
      n_err++; $display("FAIL rmid_repress: got %h expected %h", dut_out, exp_out());
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_swap();
    test_priority();
    test_bounce();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
